// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// Build option: define PS2_TX_RETRY_EN to retry a failed byte once.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       PS2CLK_IN,
  input  logic       PS2DATA_IN,
  output logic       PS2CLK_OE,
  output logic       PS2DATA_OE,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR
);

  localparam int CNT_MAX =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
  // TX_ERR registers one cycle after the match, so it lands
  // exactly TIMEOUT_CYCLES after the REQ cycle.
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE
  } state_t;

  state_t state, state_d;

  logic [FILTER_LEN-1:0] clk_sr, dat_sr;
  logic                  clk_f, dat_f;
  logic                  clk_fall;

  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bits, bits_d;
  logic [10:0]   shift, shift_d;
  logic          nack, nack_d;
  logic          clk_oe_d, dat_oe_d;
  logic          busy_d, done_d, err_d;
  logic          fail;

`ifdef PS2_TX_RETRY_EN
  logic [7:0] byte_q, byte_d;
  logic       retried, retried_d;
`endif

  // {stop, odd parity, data, start}; start is bit 0
  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // glitch filter: level changes only when the window agrees
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      clk_sr <= '0;
      dat_sr <= '0;
      clk_f  <= 1'b0;
      dat_f  <= 1'b0;
    end else begin
      clk_sr <= {clk_sr[FILTER_LEN-2:0], PS2CLK_IN};
      dat_sr <= {dat_sr[FILTER_LEN-2:0], PS2DATA_IN};
      if (&clk_sr)       clk_f <= 1'b1;
      else if (~|clk_sr) clk_f <= 1'b0;
      if (&dat_sr)       dat_f <= 1'b1;
      else if (~|dat_sr) dat_f <= 1'b0;
    end
  end

  assign clk_fall = clk_f & ~|clk_sr;

  // state, datapath and registered line enables
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      bits       <= '0;
      shift      <= '0;
      nack       <= 1'b0;
      PS2CLK_OE  <= 1'b0;
      PS2DATA_OE <= 1'b0;
      TX_BUSY    <= 1'b0;
      TX_DONE    <= 1'b0;
      TX_ERR     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      byte_q     <= '0;
      retried    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bits       <= bits_d;
      shift      <= shift_d;
      nack       <= nack_d;
      PS2CLK_OE  <= clk_oe_d;
      PS2DATA_OE <= dat_oe_d;
      TX_BUSY    <= busy_d;
      TX_DONE    <= done_d;
      TX_ERR     <= err_d;
`ifdef PS2_TX_RETRY_EN
      byte_q     <= byte_d;
      retried    <= retried_d;
`endif
    end
  end

  // next-state and next-output decode
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bits_d   = bits;
    shift_d  = shift;
    nack_d   = nack;
    clk_oe_d = PS2CLK_OE;
    dat_oe_d = PS2DATA_OE;
    busy_d   = TX_BUSY;
    done_d   = 1'b0;
    err_d    = 1'b0;
    fail     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d    = byte_q;
    retried_d = retried;
`endif

    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (TX_START && !TX_BUSY) begin
          shift_d  = frame(TX_DATA);
          cnt_d    = '0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          byte_d    = TX_DATA;
          retried_d = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        cnt_d = cnt + 1'b1;
        if (cnt == INH_DATA) begin
          dat_oe_d = ~shift[0];
          shift_d  = {1'b1, shift[10:1]};
        end
        if (cnt == INH_LAST) begin
          clk_oe_d = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        cnt_d    = '0;
        bits_d   = '0;
        dat_oe_d = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt + 1'b1;
        if (clk_fall) begin
          dat_oe_d = ~shift[0];
          shift_d  = {1'b1, shift[10:1]};
          bits_d   = bits + 1'b1;
          if (bits == 4'd9) state_d = ACK;
        end
        if (cnt == TO_LAST) fail = 1'b1;
      end
      ACK: begin
        cnt_d = cnt + 1'b1;
        if (clk_fall) begin
          nack_d  = dat_f;
          state_d = RELEASE;
        end
        if (cnt == TO_LAST) fail = 1'b1;
      end
      RELEASE: begin
        if (clk_f && dat_f) begin
          if (nack) begin
            fail = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_RETRY_EN
    if (fail && !retried) begin
      retried_d = 1'b1;
      shift_d   = frame(byte_q);
      cnt_d     = '0;
      clk_oe_d  = 1'b1;
      dat_oe_d  = 1'b0;
      state_d   = INHIBIT;
    end else if (fail) begin
      err_d    = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      state_d  = IDLE;
    end
`else
    if (fail) begin
      err_d    = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      state_d  = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2
// device model (clocking, ack/nack, stall, glitch injection).
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int TO  = 3000;
  localparam int H   = 40;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] TX_DATA = '0;
  logic       TX_START = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       glitch = 1'b0;
  logic       PS2CLK_IN, PS2DATA_IN;
  logic       PS2CLK_OE, PS2DATA_OE;
  logic       TX_BUSY, TX_DONE, TX_ERR;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int oe_hi = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int req_cyc = 0;
  int err_cyc = 0;
  logic [1:0] oe_at_err = '0;
  logic busy_at_done = 1'b0;
  logic busy_after = 1'b0;
  logic prev_oe = 1'b0;
  logic prev_pulse = 1'b0;

  assign PS2CLK_IN  = ~PS2CLK_OE & dev_clk & ~glitch;
  assign PS2DATA_IN = ~PS2DATA_OE & dev_dat;

  always #5 CLK = ~CLK;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(8)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .TX_DATA(TX_DATA),
    .TX_START(TX_START),
    .PS2CLK_IN(PS2CLK_IN),
    .PS2DATA_IN(PS2DATA_IN),
    .PS2CLK_OE(PS2CLK_OE),
    .PS2DATA_OE(PS2DATA_OE),
    .TX_BUSY(TX_BUSY),
    .TX_DONE(TX_DONE),
    .TX_ERR(TX_ERR)
  );

  // output monitor, sampled mid-cycle
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (PS2CLK_OE) oe_hi = oe_hi + 1;
    if (prev_oe && !PS2CLK_OE) req_cyc = cyc;
    if (TX_DONE) begin
      n_done = n_done + 1;
      busy_at_done = TX_BUSY;
    end
    if (TX_ERR) begin
      n_err = n_err + 1;
      err_cyc = cyc;
      oe_at_err = {PS2CLK_OE, PS2DATA_OE};
    end
    if (TX_DONE && TX_ERR) n_both = n_both + 1;
    if (prev_pulse) busy_after = TX_BUSY;
    prev_pulse = TX_DONE | TX_ERR;
    prev_oe = PS2CLK_OE;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    TX_DATA = b;
    TX_START = 1'b1;
    @(negedge CLK);
    TX_START = 1'b0;
  endtask

  task automatic device(input int nclk, input bit ack,
                        input bit glt,
                        output logic [10:0] seen,
                        output bit ok);
    int t;
    seen = '0;
    ok = 1'b0;
    t = 0;
    while (!PS2CLK_OE && t < 6000) begin
      @(negedge CLK);
      t++;
    end
    while (PS2CLK_OE && t < 6000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 6000) return;
    ok = 1'b1;
    repeat (H) @(negedge CLK);
    seen[0] = PS2DATA_IN;
    for (int i = 1; i <= nclk; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge CLK);
      dev_clk = 1'b1;
      if (i <= 10) seen[i[3:0]] = PS2DATA_IN;
      if (glt && i == 3) begin
        repeat (10) @(negedge CLK);
        glitch = 1'b1;
        repeat (3) @(negedge CLK);
        glitch = 1'b0;
        repeat (H - 13) @(negedge CLK);
      end else if (ack && i == 10) begin
        repeat (H / 2) @(negedge CLK);
        dev_dat = 1'b0;
        repeat (H - H / 2) @(negedge CLK);
      end else begin
        repeat (H) @(negedge CLK);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_pulse(input string tag, input int d0,
                            input int e0);
    int t;
    t = 0;
    while (n_done == d0 && n_err == e0 && t < 8000) begin
      @(negedge CLK);
      t++;
    end
    check(tag, 32'(t < 8000), 32'd1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic xfer(input string tag, input logic [7:0] b,
                      input logic [10:0] exp_bits,
                      input bit glt, input bit poke);
    int d0, e0, o0;
    logic [10:0] seen;
    bit ok;
    d0 = n_done;
    e0 = n_err;
    o0 = oe_hi;
    send(b);
    fork
      device(11, 1'b1, glt, seen, ok);
      if (poke) begin
        repeat (400) @(negedge CLK);
        TX_DATA = 8'hFF;
        TX_START = 1'b1;
        @(negedge CLK);
        TX_START = 1'b0;
      end
    join
    check({tag, "_sync"}, 32'(ok), 32'd1);
    check({tag, "_bits"}, 32'(seen), 32'(exp_bits));
    wait_pulse({tag, "_wait"}, d0, e0);
    check({tag, "_inh"}, oe_hi - o0, INH);
    check({tag, "_done"}, n_done - d0, 1);
    check({tag, "_err"}, n_err - e0, 0);
    check({tag, "_busy_pulse"}, 32'(busy_at_done), 32'd1);
    check({tag, "_busy_after"}, 32'(busy_after), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, o0;
    logic [10:0] seen;
    bit ok;

    // reset with a start request held high
    RST_N = 1'b0;
    TX_DATA = 8'hED;
    TX_START = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_clk_oe", 32'(PS2CLK_OE), 32'd0);
    check("rst_dat_oe", 32'(PS2DATA_OE), 32'd0);
    check("rst_busy", 32'(TX_BUSY), 32'd0);
    check("rst_pulses", 32'({TX_DONE, TX_ERR}), 32'd0);
    TX_START = 1'b0;
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("rst_no_start", 32'({TX_BUSY, PS2CLK_OE}), 32'd0);

    // ED with a mid-transfer start and a clock glitch
    xfer("ed", 8'hED, 11'h7DA, 1'b1, 1'b1);
    // parity vectors
    xfer("p00", 8'h00, 11'h600, 1'b0, 1'b0);
    xfer("pff", 8'hFF, 11'h7FE, 1'b0, 1'b0);
    xfer("p01", 8'h01, 11'h402, 1'b0, 1'b0);

    // nack
    d0 = n_done;
    e0 = n_err;
    o0 = oe_hi;
    send(8'hF3);
    device(11, 1'b0, 1'b0, seen, ok);
    check("nack_sync", 32'(ok), 32'd1);
    check("nack_bits", 32'(seen), 32'h7E6);
`ifdef PS2_TX_RETRY_EN
    repeat (5) @(negedge CLK);
    check("nack_no_early_err", n_err - e0, 0);
    device(11, 1'b0, 1'b0, seen, ok);
    check("nack_retry_sync", 32'(ok), 32'd1);
    check("nack_retry_bits", 32'(seen), 32'h7E6);
    wait_pulse("nack_wait", d0, e0);
    check("nack_inh", oe_hi - o0, 2 * INH);
`else
    wait_pulse("nack_wait", d0, e0);
    check("nack_inh", oe_hi - o0, INH);
`endif
    check("nack_err", n_err - e0, 1);
    check("nack_done", n_done - d0, 0);
    check("nack_busy_after", 32'(busy_after), 32'd0);

    // timeout: device stops after four clocks
    d0 = n_done;
    e0 = n_err;
    send(8'h01);
    device(4, 1'b0, 1'b0, seen, ok);
    check("to_sync", 32'(ok), 32'd1);
`ifdef PS2_TX_RETRY_EN
    device(4, 1'b0, 1'b0, seen, ok);
    check("to_retry_sync", 32'(ok), 32'd1);
`endif
    wait_pulse("to_wait", d0, e0);
    check("to_latency", err_cyc - req_cyc, TO);
    check("to_oe", 32'(oe_at_err), 32'd0);
    check("to_err", n_err - e0, 1);
    check("to_done", n_done - d0, 0);
    check("to_busy_after", 32'(busy_after), 32'd0);

    // reset in the middle of INHIBIT
    send(8'hED);
    repeat (50) @(negedge CLK);
    check("mid_oe_pre", 32'(PS2CLK_OE), 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    check("mid_rst_oe", 32'({PS2CLK_OE, PS2DATA_OE}), 32'd0);
    check("mid_rst_busy", 32'(TX_BUSY), 32'd0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    check("never_both", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
